prewish_pattern_blinker: RTL and testbench

Downstream consumer of the mentor's strobe/data output. It captures each 8-bit mask presented with a strobe and plays it out serially on an LED output, MSB first. Each bit is held for a fixed prescaled interval, and the 8-bit pattern repeats indefinitely until a new mask arrives. It is the final stage between the mentor and the board LED pin.

---
 rtl/prewish_pattern_blinker_if.sv | 16 +
 rtl/prewish_pattern_blinker.sv | 79 +++++++
 tb/tb_prewish_pattern_blinker.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/prewish_pattern_blinker_if.sv
// Load bus from the mentor: level strobe plus 8-bit mask.
// master drives STB_I/DAT_I, slave (the blinker) samples them.
interface prewish_pattern_blinker_if;
  logic       STB_I;
  logic [7:0] DAT_I;

  modport master (
    output STB_I,
    output DAT_I
  );

  modport slave (
    input STB_I,
    input DAT_I
  );
endinterface

// File: rtl/prewish_pattern_blinker.sv
// Plays a strobed 8-bit mask on o_led, MSB first, 2^PRESCALE_W clocks/bit.
// Ports: CLK_I, RST_I (async low), bus (STB_I/DAT_I), o_led, o_running, o_alive.
module prewish_pattern_blinker #(
  parameter int PRESCALE_W = 22
) (
  input  logic CLK_I,
  input  logic RST_I,
  prewish_pattern_blinker_if.slave bus,
  output logic o_led,
  output logic o_running,
  output logic o_alive
);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t                r_state;
  logic                  r_stb_q;
  logic [7:0]            r_mask;
  logic [2:0]            r_idx;
  logic [PRESCALE_W-1:0] r_presc;
  logic                  r_led;
  logic                  r_alive;

  logic                  w_load;
  logic                  w_tick;
  logic [2:0]            w_idx_nxt;

  // One load per strobe rising edge, however long it stays high.
  assign w_load    = bus.STB_I & ~r_stb_q;
  assign w_tick    = &r_presc;
  assign w_idx_nxt = r_idx - 3'd1;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_state <= ST_IDLE;
      r_stb_q <= 1'b0;
      r_mask  <= 8'h00;
      r_idx   <= 3'd7;
      r_presc <= '0;
      r_led   <= 1'b0;
      r_alive <= 1'b0;
    end else begin
      r_stb_q <= bus.STB_I;
      // A load on a tick edge wins; the tick is dropped.
      if (w_load) begin
        r_state <= ST_RUN;
        r_mask  <= bus.DAT_I;
        r_idx   <= 3'd7;
        r_presc <= '0;
        r_led   <= bus.DAT_I[7];
        r_alive <= ~r_alive;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            r_led <= 1'b0;
          end
          ST_RUN: begin
            r_presc <= r_presc + 1'b1;
            if (w_tick) begin
              r_idx <= w_idx_nxt;
              r_led <= r_mask[w_idx_nxt];
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_led     = r_led;
  assign o_running = (r_state == ST_RUN);
  assign o_alive   = r_alive;

endmodule

// File: tb/tb_prewish_pattern_blinker.sv
// Bench for prewish_pattern_blinker at PRESCALE_W=2.
// Expected LED bits are queued at stimulus time, popped per clock.
module tb_prewish_pattern_blinker;

  localparam int PW  = 2;
  localparam int BPC = 1 << PW;

  logic clk;
  logic rst_n;
  logic o_led;
  logic o_running;
  logic o_alive;

  int errors;
  int checks;
  logic q_exp[$];
  logic exp_b;

  prewish_pattern_blinker_if bus ();

  prewish_pattern_blinker #(
    .PRESCALE_W(PW)
  ) dut (
    .CLK_I    (clk),
    .RST_I    (rst_n),
    .bus      (bus.slave),
    .o_led    (o_led),
    .o_running(o_running),
    .o_alive  (o_alive)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected playback of mask m for n clocks starting at bit 7.
  task automatic push_pat(input logic [7:0] m, input int n);
    for (int i = 0; i < n; i++) begin
      q_exp.push_back(m[7 - ((i / BPC) % 8)]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.STB_I = 1'b0;
    bus.DAT_I = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({o_led, o_running, o_alive} !== 3'b000) begin
        errors++;
        $display("FAIL reset_hold: got led/run/alive=%b required 000",
                 {o_led, o_running, o_alive});
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({o_led, o_running, o_alive} !== 3'b000) begin
        errors++;
        $display("FAIL reset_idle c%0d: got %b required 000",
                 i, {o_led, o_running, o_alive});
      end
    end
  endtask

  task automatic test_basic();
    bus.STB_I = 1'b1;
    bus.DAT_I = 8'hB4;
    push_pat(8'hB4, 40);
    tick();
    for (int i = 0; i < 40; i++) begin
      if (i > 0) tick();
      if (i == 1) bus.STB_I = 1'b0;
      exp_b = q_exp.pop_front();
      checks++;
      if (o_led !== exp_b) begin
        errors++;
        $display("FAIL basic_led c%0d: got %b required %b", i, o_led, exp_b);
      end
    end
    checks++;
    if ({o_running, o_alive} !== 2'b11) begin
      errors++;
      $display("FAIL basic_flags: got run/alive=%b required 11",
               {o_running, o_alive});
    end
  endtask

  task automatic test_level_strobe();
    tick();
    bus.STB_I = 1'b1;
    bus.DAT_I = 8'h81;
    push_pat(8'h81, 50);
    tick();
    for (int i = 0; i < 50; i++) begin
      if (i > 0) tick();
      if (i == 10) bus.DAT_I = 8'h00;
      exp_b = q_exp.pop_front();
      checks++;
      if (o_led !== exp_b) begin
        errors++;
        $display("FAIL level_led c%0d: got %b required %b", i, o_led, exp_b);
      end
    end
    bus.STB_I = 1'b0;
    checks++;
    if (o_alive !== 1'b0) begin
      errors++;
      $display("FAIL level_alive: got %b required 0", o_alive);
    end
  endtask

  task automatic test_reload();
    tick();
    bus.STB_I = 1'b1;
    bus.DAT_I = 8'hF0;
    push_pat(8'hF0, 9);
    tick();
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      if (i == 0) bus.STB_I = 1'b0;
      exp_b = q_exp.pop_front();
      checks++;
      if (o_led !== exp_b) begin
        errors++;
        $display("FAIL reload_a c%0d: got %b required %b", i, o_led, exp_b);
      end
    end
    checks++;
    if (o_alive !== 1'b1) begin
      errors++;
      $display("FAIL reload_alive1: got %b required 1", o_alive);
    end
    bus.STB_I = 1'b1;
    bus.DAT_I = 8'h0F;
    push_pat(8'h0F, 32);
    tick();
    for (int i = 0; i < 32; i++) begin
      if (i > 0) tick();
      if (i == 0) bus.STB_I = 1'b0;
      exp_b = q_exp.pop_front();
      checks++;
      if (o_led !== exp_b) begin
        errors++;
        $display("FAIL reload_b c%0d: got %b required %b", i, o_led, exp_b);
      end
    end
    checks++;
    if (o_alive !== 1'b0) begin
      errors++;
      $display("FAIL reload_alive0: got %b required 0", o_alive);
    end
  endtask

  task automatic test_collision();
    tick();
    bus.STB_I = 1'b1;
    bus.DAT_I = 8'hA5;
    push_pat(8'hA5, 4);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      if (i == 0) bus.STB_I = 1'b0;
      exp_b = q_exp.pop_front();
      checks++;
      if (o_led !== exp_b) begin
        errors++;
        $display("FAIL coll_a c%0d: got %b required %b", i, o_led, exp_b);
      end
    end
    // Next edge is the tick edge of bit 7; load lands on it.
    bus.STB_I = 1'b1;
    bus.DAT_I = 8'hC3;
    push_pat(8'hC3, 36);
    tick();
    for (int i = 0; i < 36; i++) begin
      if (i > 0) tick();
      if (i == 0) bus.STB_I = 1'b0;
      exp_b = q_exp.pop_front();
      checks++;
      if (o_led !== exp_b) begin
        errors++;
        $display("FAIL coll_b c%0d: got %b required %b", i, o_led, exp_b);
      end
    end
  endtask

  task automatic test_async_reset();
    tick();
    bus.STB_I = 1'b1;
    bus.DAT_I = 8'hFF;
    push_pat(8'hFF, 6);
    tick();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      if (i == 0) bus.STB_I = 1'b0;
      exp_b = q_exp.pop_front();
      checks++;
      if (o_led !== exp_b) begin
        errors++;
        $display("FAIL ares_pre c%0d: got %b required %b", i, o_led, exp_b);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_led, o_running, o_alive} !== 3'b000) begin
      errors++;
      $display("FAIL ares_now: got led/run/alive=%b required 000",
               {o_led, o_running, o_alive});
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({o_led, o_running} !== 2'b00) begin
        errors++;
        $display("FAIL ares_idle c%0d: got led/run=%b required 00",
                 i, {o_led, o_running});
      end
    end
    bus.STB_I = 1'b1;
    bus.DAT_I = 8'h80;
    push_pat(8'h80, 12);
    tick();
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      if (i == 0) bus.STB_I = 1'b0;
      exp_b = q_exp.pop_front();
      checks++;
      if (o_led !== exp_b) begin
        errors++;
        $display("FAIL ares_post c%0d: got %b required %b", i, o_led, exp_b);
      end
    end
    checks++;
    if ({o_running, o_alive} !== 2'b11) begin
      errors++;
      $display("FAIL ares_flags: got run/alive=%b required 11",
               {o_running, o_alive});
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.STB_I = 1'b0;
    bus.DAT_I = 8'h00;
    test_reset();
    test_basic();
    test_level_strobe();
    test_reload();
    test_collision();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
